// File: rtl/formula_1_shared_sched_if.sv
// Signals between the triad source, the scheduler, the shared isqrt and the result sink.
interface formula_1_shared_sched_if #(
  parameter int ARG_W = 32,
  parameter int Y_W   = 16,
  parameter int RES_W = 32
);
  logic             arg_vld;
  logic             arg_rdy;
  logic [ARG_W-1:0] a;
  logic [ARG_W-1:0] b;
  logic [ARG_W-1:0] c;
  logic             sqrt_x_vld;
  logic [ARG_W-1:0] sqrt_x;
  logic             sqrt_y_vld;
  logic [Y_W-1:0]   sqrt_y;
  logic             res_vld;
  logic [RES_W-1:0] res;
  logic             err;

  modport slave (
    input  arg_vld, a, b, c, sqrt_y_vld, sqrt_y,
    output arg_rdy, sqrt_x_vld, sqrt_x, res_vld, res, err
  );

  modport master (
    output arg_vld, a, b, c, sqrt_y_vld, sqrt_y,
    input  arg_rdy, sqrt_x_vld, sqrt_x, res_vld, res, err
  );
endinterface

// File: rtl/formula_1_shared_sched.sv
// Time-multiplexes one pipelined isqrt across a, b, c and sums the three in-order results.
//   state | meaning
//   IDLE  | no issue this cycle, ready for a triad
//   S_A   | issuing a
//   S_B   | issuing b
//   S_C   | issuing c, ready for the next triad
module formula_1_shared_sched #(
  parameter int ARG_W = 32,
  parameter int Y_W   = 16,
  parameter int RES_W = 32,
  parameter int CNT_W = 8
) (
  input logic                     clk,
  input logic                     rst,
  formula_1_shared_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, S_A, S_B, S_C} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             arg_rdy;
  logic             accept;
  logic [ARG_W-1:0] b_q;
  logic [ARG_W-1:0] c_q;
  logic             x_vld_q;
  logic [ARG_W-1:0] x_q;
  logic             issue_vld_nxt;
  logic [ARG_W-1:0] issue_x_nxt;

  logic [1:0]       phase;
  logic [CNT_W-1:0] inflight;
  logic [RES_W-1:0] acc;
  logic [RES_W-1:0] y_ext;
  logic             ret;
  logic             stray;
  logic             res_vld_q;
  logic [RES_W-1:0] res_q;
  logic             err_q;

  assign arg_rdy = (state == IDLE) || (state == S_C);
  assign accept  = bus.arg_vld && arg_rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      b_q     <= '0;
      c_q     <= '0;
      x_vld_q <= 1'b0;
      x_q     <= '0;
    end else begin
      state   <= state_nxt;
      x_vld_q <= issue_vld_nxt;
      x_q     <= issue_x_nxt;
      if (accept) begin
        b_q <= bus.b;
        c_q <= bus.c;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = S_A;
      S_A:  state_nxt = S_B;
      S_B:  state_nxt = S_C;
      S_C:  state_nxt = accept ? S_A : IDLE;
    endcase
  end

  // a is taken straight from the bus: it is issued on the cycle right after the accept edge.
  always_comb begin
    issue_vld_nxt = 1'b1;
    issue_x_nxt   = x_q;
    unique case (state_nxt)
      IDLE: issue_vld_nxt = 1'b0;
      S_A:  issue_x_nxt   = bus.a;
      S_B:  issue_x_nxt   = b_q;
      S_C:  issue_x_nxt   = c_q;
    endcase
  end

  assign y_ext = {{(RES_W-Y_W){1'b0}}, bus.sqrt_y};
  assign ret   = bus.sqrt_y_vld && (inflight != '0);
  assign stray = bus.sqrt_y_vld && (inflight == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase     <= 2'd0;
      inflight  <= '0;
      acc       <= '0;
      res_vld_q <= 1'b0;
      res_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      res_vld_q <= 1'b0;
      if (stray) err_q <= 1'b1;
      if (x_vld_q && !ret)      inflight <= inflight + CNT_W'(1);
      else if (!x_vld_q && ret) inflight <= inflight - CNT_W'(1);
      if (ret) begin
        unique case (phase)
          2'd0: begin
            acc   <= y_ext;
            phase <= 2'd1;
          end
          2'd1: begin
            acc   <= acc + y_ext;
            phase <= 2'd2;
          end
          default: begin
            res_q     <= acc + y_ext;
            res_vld_q <= 1'b1;
            phase     <= 2'd0;
          end
        endcase
      end
    end
  end

  assign bus.arg_rdy    = arg_rdy;
  assign bus.sqrt_x_vld = x_vld_q;
  assign bus.sqrt_x     = x_q;
  assign bus.res_vld    = res_vld_q;
  assign bus.res        = res_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_formula_1_shared_sched.sv
// Bench for the shared-isqrt scheduler: behavioural isqrt with latency 16 plus a cycle-level scoreboard.
module tb_formula_1_shared_sched;
  localparam int L = 16;

  logic clk;
  logic rst;
  logic inject;
  int   cyc;
  int   checks;
  int   errors;

  formula_1_shared_sched_if #(.ARG_W(32), .Y_W(16), .RES_W(32)) bus ();

  formula_1_shared_sched #(.ARG_W(32), .Y_W(16), .RES_W(32), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] isqrt(input logic [31:0] x);
    longint lo, hi, m;
    lo = 0;
    hi = 65535;
    while (lo < hi) begin
      m = (lo + hi + 1) / 2;
      if (m * m <= longint'(x)) lo = m;
      else hi = m - 1;
    end
    return 16'(lo);
  endfunction

  function automatic logic [31:0] tri_sum(input logic [31:0] x, y, z);
    return 32'(isqrt(x)) + 32'(isqrt(y)) + 32'(isqrt(z));
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Shared isqrt: fixed latency L, in order, reset together with the scheduler.
  logic        pv [L];
  logic [15:0] py [L];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < L; i++) begin
        pv[i] <= 1'b0;
        py[i] <= '0;
      end
    end else begin
      pv[0] <= bus.sqrt_x_vld;
      py[0] <= isqrt(bus.sqrt_x);
      for (int i = 1; i < L; i++) begin
        pv[i] <= pv[i-1];
        py[i] <= py[i-1];
      end
    end
  end
  assign bus.sqrt_y_vld = pv[L-1] | inject;
  assign bus.sqrt_y     = py[L-1];

  // Scoreboard: expected issue beats and results keyed by cycle number.
  typedef struct {
    int          at;
    logic [31:0] val;
  } ev_t;
  ev_t         iq[$];
  ev_t         rq[$];
  int          last_acc;
  logic [31:0] last_x;
  int          outstanding;
  logic        exp_err;

  always @(negedge clk) begin
    logic        exp_rdy, exp_xv, exp_rv;
    logic [31:0] exp_res;
    if (!rst) begin
      iq.delete();
      rq.delete();
      last_acc    = -100;
      last_x      = '0;
      outstanding = 0;
      exp_err     = 1'b0;
    end else begin
      exp_rdy = (cyc - last_acc) >= 3;
      check("arg_rdy", bus.arg_rdy, exp_rdy);
      exp_xv = 1'b0;
      if (iq.size() > 0 && iq[0].at == cyc) begin
        exp_xv = 1'b1;
        last_x = iq[0].val;
        void'(iq.pop_front());
      end
      check("sqrt_x_vld", bus.sqrt_x_vld, exp_xv);
      check("sqrt_x", bus.sqrt_x, last_x);
      exp_rv  = 1'b0;
      exp_res = 'x;
      if (rq.size() > 0 && rq[0].at == cyc) begin
        exp_rv  = 1'b1;
        exp_res = rq[0].val;
        void'(rq.pop_front());
      end
      check("res_vld", bus.res_vld, exp_rv);
      if (exp_rv) check("res", bus.res, exp_res);
      check("err", bus.err, exp_err);
      if (bus.sqrt_y_vld) begin
        if (outstanding == 0) exp_err = 1'b1;
        else outstanding--;
      end
      if (exp_xv) outstanding++;
      if (bus.arg_vld && exp_rdy) begin
        last_acc = cyc;
        iq.push_back('{cyc + 1, bus.a});
        iq.push_back('{cyc + 2, bus.b});
        iq.push_back('{cyc + 3, bus.c});
        rq.push_back('{cyc + L + 4, tri_sum(bus.a, bus.b, bus.c)});
      end
    end
  end

  task automatic send(input logic [31:0] va, vb, vc, input bit churn, output int at);
    bus.arg_vld = 1'b1;
    bus.a = va;
    bus.b = vb;
    bus.c = vc;
    at = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.arg_rdy === 1'b1) begin
        at = cyc;
        break;
      end
      @(posedge clk);
      #1;
      if (churn) begin
        bus.a = $urandom;
        bus.b = $urandom;
        bus.c = $urandom;
      end
    end
    check("accept_seen", at >= 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_res(output logic [31:0] v, output int at);
    v  = '0;
    at = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.res_vld === 1'b1) begin
        v  = bus.res;
        at = cyc;
        break;
      end
    end
    check("res_seen", at >= 0, 1);
  endtask

  task automatic idle(input int n);
    bus.arg_vld = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int          t_acc, t_res;
    int          ats[4];
    logic [31:0] v;
    logic [31:0] exp4[4];
    checks = 0;
    errors = 0;
    rst = 1'b0;
    inject = 1'b0;
    bus.arg_vld = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.c = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_x_vld", bus.sqrt_x_vld, 0);
    check("rst_x", bus.sqrt_x, 0);
    check("rst_res_vld", bus.res_vld, 0);
    check("rst_res", bus.res, 0);
    check("rst_err", bus.err, 0);
    rst = 1'b1;
    idle(2);

    // single triad, latency and issue order
    send(16, 25, 36, 0, t_acc);
    bus.arg_vld = 1'b0;
    wait_res(v, t_res);
    check("t1_res", v, 15);
    check("t1_latency", t_res - t_acc, L + 4);
    idle(3);

    // truncation and extremes
    send(17, 0, 32'hFFFF_FFFF, 0, t_acc);
    bus.arg_vld = 1'b0;
    wait_res(v, t_res);
    check("t2_res", v, 65539);
    idle(3);

    // back-to-back triads
    send(1, 4, 9, 0, ats[0]);
    send(4, 9, 16, 0, ats[1]);
    send(9, 16, 25, 0, ats[2]);
    send(16, 25, 36, 0, ats[3]);
    bus.arg_vld = 1'b0;
    for (int i = 1; i < 4; i++) check("t3_accept_gap", ats[i] - ats[i-1], 3);
    exp4 = '{6, 9, 12, 15};
    for (int i = 0; i < 4; i++) begin
      wait_res(v, ats[i]);
      check("t3_res", v, exp4[i]);
    end
    for (int i = 1; i < 4; i++) check("t3_res_gap", ats[i] - ats[i-1], 3);
    idle(3);

    // operands offered while busy are not taken until S_C
    send(100, 400, 900, 0, t_acc);
    bus.a = 32'hDEAD;
    bus.b = 32'hBEEF;
    bus.c = 32'hCAFE;
    @(negedge clk);
    check("t4_rdy_sa", bus.arg_rdy, 0);
    @(posedge clk);
    #1;
    bus.a = 32'h1234;
    @(negedge clk);
    check("t4_rdy_sb", bus.arg_rdy, 0);
    @(posedge clk);
    #1;
    bus.a = 49;
    bus.b = 64;
    bus.c = 81;
    @(negedge clk);
    check("t4_rdy_sc", bus.arg_rdy, 1);
    @(posedge clk);
    #1;
    bus.arg_vld = 1'b0;
    wait_res(v, t_res);
    check("t4_res0", v, 60);
    wait_res(v, t_res);
    check("t4_res1", v, 24);
    idle(25);

    // stray return with nothing in flight
    inject = 1'b1;
    @(posedge clk);
    #1;
    inject = 1'b0;
    idle(2);
    check("t6_err", bus.err, 1);
    check("t6_res_vld", bus.res_vld, 0);
    send(4, 4, 4, 0, t_acc);
    bus.arg_vld = 1'b0;
    wait_res(v, t_res);
    check("t6_res_after", v, 6);
    check("t6_err_sticky", bus.err, 1);
    idle(3);

    // async reset mid-triad, after b has been issued
    send(100, 200, 300, 0, t_acc);
    bus.arg_vld = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("t5_x_vld", bus.sqrt_x_vld, 0);
    check("t5_x", bus.sqrt_x, 0);
    check("t5_err", bus.err, 0);
    check("t5_res", bus.res, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    send(1, 1, 1, 0, t_acc);
    bus.arg_vld = 1'b0;
    wait_res(v, t_res);
    check("t5_res_after", v, 3);
    check("t5_latency", t_res - t_acc, L + 4);

    // randomized traffic, scoreboard checks every cycle
    for (int n = 0; n < 40; n++) begin
      logic [31:0] ra, rb, rc;
      ra = $urandom >> $urandom_range(0, 31);
      rb = $urandom >> $urandom_range(0, 31);
      rc = $urandom >> $urandom_range(0, 31);
      send(ra, rb, rc, $urandom_range(0, 1) == 1, t_acc);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
      if ($urandom_range(0, 3) == 0) begin
        bus.a = $urandom;
        bus.b = $urandom;
        bus.c = $urandom;
      end
    end
    idle(L + 10);
    check("drain_res", rq.size(), 0);
    check("drain_issue", iq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
